// File: rtl/id_field_stage_pkg.sv
// Shared definitions for the decode field stage: destination-select codes
// and the bit positions of the fixed 32-bit instruction fields.
package id_field_stage_pkg;

    typedef enum logic [1:0] {
        DST_RD   = 2'd0,
        DST_RT   = 2'd1,
        DST_LINK = 2'd2,
        DST_NONE = 2'd3
    } dst_sel_e;

    localparam int INSTR_W     = 32;
    localparam int LINK_OFFSET = 8;

    localparam int OPC_HI  = 31;
    localparam int OPC_LO  = 26;
    localparam int RS_HI   = 25;
    localparam int RS_LO   = 21;
    localparam int RT_HI   = 20;
    localparam int RT_LO   = 16;
    localparam int RD_HI   = 15;
    localparam int RD_LO   = 11;
    localparam int IMM_HI  = 15;
    localparam int IMM_LO  = 0;
    localparam int FUNC_HI = 5;
    localparam int FUNC_LO = 0;
    localparam int JIDX_HI = 25;
    localparam int JIDX_LO = 0;

endpackage

// File: rtl/id_field_split.sv
// Combinational slicing of an instruction word into decode fields plus
// destination-register selection; all outputs are zero when not valid.
module id_field_split
    import id_field_stage_pkg::*;
#(
    parameter int REG_W    = 5,
    parameter int LINK_REG = 31
) (
    input  logic               valid,
    input  logic [INSTR_W-1:0] instr,
    input  logic [1:0]         dst_sel,
    output logic [5:0]         opcode,
    output logic [REG_W-1:0]   rs,
    output logic [REG_W-1:0]   rt,
    output logic [REG_W-1:0]   dst,
    output logic [15:0]        imm,
    output logic [5:0]         func,
    output logic [25:0]        jidx
);

    always_comb begin
        opcode = '0;
        rs     = '0;
        rt     = '0;
        dst    = '0;
        imm    = '0;
        func   = '0;
        jidx   = '0;
        if (valid) begin
            opcode = instr[OPC_HI:OPC_LO];
            // Register fields are always 5 bits wide in the word; fit them to REG_W.
            rs     = REG_W'(instr[RS_HI:RS_LO]);
            rt     = REG_W'(instr[RT_HI:RT_LO]);
            imm    = instr[IMM_HI:IMM_LO];
            func   = instr[FUNC_HI:FUNC_LO];
            jidx   = instr[JIDX_HI:JIDX_LO];
            case (dst_sel)
                DST_RD:   dst = REG_W'(instr[RD_HI:RD_LO]);
                DST_RT:   dst = REG_W'(instr[RT_HI:RT_LO]);
                DST_LINK: dst = REG_W'(LINK_REG);
                default:  dst = '0;
            endcase
        end
    end

endmodule

// File: rtl/id_field_stage.sv
// Two-entry (head + skid) decode stage: in_ready depends only on skid
// occupancy, the head entry feeds the field splitter, flush drops are counted.
module id_field_stage
    import id_field_stage_pkg::*;
#(
    parameter int PC_W     = 32,
    parameter int REG_W    = 5,
    parameter int LINK_REG = 31,
    parameter int CNT_W    = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [PC_W-1:0]    in_pc,
    input  logic [1:0]         in_dst_sel,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [5:0]         out_opcode,
    output logic [REG_W-1:0]   out_rs,
    output logic [REG_W-1:0]   out_rt,
    output logic [REG_W-1:0]   out_dst,
    output logic [15:0]        out_imm,
    output logic [5:0]         out_func,
    output logic [25:0]        out_jidx,
    output logic [PC_W-1:0]    out_pc,
    output logic [PC_W-1:0]    out_link_pc,
    output logic [CNT_W-1:0]   drop_cnt
);

    logic               head_valid, skid_valid;
    logic [INSTR_W-1:0] head_instr, skid_instr;
    logic [PC_W-1:0]    head_pc, skid_pc;
    logic [1:0]         head_sel, skid_sel;

    logic               accept, pop;
    logic [1:0]         held;
    logic [CNT_W:0]     drop_sum;

    assign in_ready  = ~skid_valid;
    assign out_valid = head_valid;
    assign accept    = in_valid & ~skid_valid & ~flush;
    assign pop       = head_valid & out_ready;
    assign held      = {1'b0, head_valid} + {1'b0, skid_valid};
    assign drop_sum  = {1'b0, drop_cnt} + (CNT_W+1)'(held);

    always_ff @(posedge clk) begin
        if (!reset) begin
            head_valid <= 1'b0;
            skid_valid <= 1'b0;
            head_instr <= '0;
            skid_instr <= '0;
            head_pc    <= '0;
            skid_pc    <= '0;
            head_sel   <= '0;
            skid_sel   <= '0;
            drop_cnt   <= '0;
        end else if (flush) begin
            head_valid <= 1'b0;
            skid_valid <= 1'b0;
            drop_cnt   <= drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
        end else if (pop && skid_valid) begin
            // in_ready is low here, so no new entry competes for the skid slot.
            head_instr <= skid_instr;
            head_pc    <= skid_pc;
            head_sel   <= skid_sel;
            skid_valid <= 1'b0;
        end else if (accept && (!head_valid || pop)) begin
            head_instr <= in_instr;
            head_pc    <= in_pc;
            head_sel   <= in_dst_sel;
            head_valid <= 1'b1;
        end else if (accept) begin
            skid_instr <= in_instr;
            skid_pc    <= in_pc;
            skid_sel   <= in_dst_sel;
            skid_valid <= 1'b1;
        end else if (pop) begin
            head_valid <= 1'b0;
        end
    end

    id_field_split #(
        .REG_W    (REG_W),
        .LINK_REG (LINK_REG)
    ) u_split (
        .valid   (head_valid),
        .instr   (head_instr),
        .dst_sel (head_sel),
        .opcode  (out_opcode),
        .rs      (out_rs),
        .rt      (out_rt),
        .dst     (out_dst),
        .imm     (out_imm),
        .func    (out_func),
        .jidx    (out_jidx)
    );

    assign out_pc      = head_valid ? head_pc : '0;
    assign out_link_pc = head_valid ? head_pc + PC_W'(LINK_OFFSET) : '0;

endmodule

// File: doc/id_field_stage.md
ID_FIELD_STAGE -- requirements
Module: id_field_stage

Interface
REQ-001 Parameter PC_W, default 32, program-counter width.
REQ-002 Parameter REG_W, default 5, register-address width; instruction fields rs/rt/rd occupy bits [25:21]/[20:16]/[15:11] regardless of REG_W, zero-extended or truncated to REG_W.
REQ-003 Parameter LINK_REG, default 31, destination index forced for link-type instructions.
REQ-004 Parameter CNT_W, default 16, width of the flush-drop counter.
REQ-005 Port clk  in  1  single clock; all state updates on rising edge.
REQ-006 Port reset  in  1  synchronous, active-low reset (0 = reset asserted).
REQ-007 Port in_valid  in  1  upstream instruction valid.
REQ-008 Port in_ready  out  1  stage can accept this cycle.
REQ-009 Port in_instr  in  32  raw instruction word.
REQ-010 Port in_pc  in  PC_W  instruction address.
REQ-011 Port in_dst_sel  in  2  destination select: 0 = rd field, 1 = rt field, 2 = LINK_REG, 3 = none (index 0).
REQ-012 Port flush  in  1  discard all held and incoming entries.
REQ-013 Port out_valid  out  1  decoded entry present.
REQ-014 Port out_ready  in  1  downstream consumes when high with out_valid.
REQ-015 Ports out_opcode 6, out_rs REG_W, out_rt REG_W, out_dst REG_W, out_imm 16, out_func 6, out_jidx 26, out_pc PC_W, out_link_pc PC_W  out  decoded fields of head entry.
REQ-016 Port drop_cnt  out  CNT_W  number of valid entries discarded by flush.

Function
REQ-017 Storage SHALL be two entries: head register (drives outputs) and skid register; each holds instr, pc, dst_sel, valid bit.
REQ-018 in_ready SHALL equal NOT skid_valid (registered, no combinational path from out_ready).
REQ-019 Accept SHALL occur when in_valid AND in_ready AND NOT flush.
REQ-020 Pop SHALL occur when out_valid AND out_ready.
REQ-021 Accept with head empty, or head popping and skid empty: entry SHALL load into head; out_valid high next cycle (latency 1).
REQ-022 Accept with head full, not popping: entry SHALL load into skid.
REQ-023 Pop with skid full: skid SHALL move to head same edge; a simultaneous accept is impossible (in_ready low).
REQ-024 Order SHALL be strictly FIFO; no entry duplicated or lost except by flush.
REQ-025 Output fields SHALL be combinational slices of head: opcode [31:26], rs [25:21], rt [20:16], imm [15:0], func [5:0], jidx [25:0].
REQ-026 out_dst SHALL be rd/rt/LINK_REG/0 per head dst_sel.
REQ-027 out_link_pc SHALL be out_pc + 8, modulo 2^PC_W.
REQ-028 When out_valid is low, all field outputs SHALL be 0.
REQ-029 Flush SHALL clear both valid bits at the next edge, overriding accept and pop; in_instr offered that cycle is dropped.
REQ-030 On flush, drop_cnt SHALL add the count of valid held entries (0, 1 or 2), saturating at all-ones; an un-accepted incoming entry does not count.
REQ-031 out_valid held high with out_ready low SHALL keep all outputs stable.

Reset
REQ-032 While reset=0 at a clock edge: both valid bits 0, stored instr/pc/dst_sel 0, drop_cnt 0.
REQ-033 After reset: out_valid 0, in_ready 1, all field outputs 0.
REQ-034 Reset mid-transfer SHALL discard held entries without incrementing drop_cnt; reset overrides flush.

Structure
REQ-035 Shared package SHALL hold dst_sel encodings (DST_RD, DST_RT, DST_LINK, DST_NONE) and instruction field bit positions.
REQ-036 Field slicing and destination select SHALL be one combinational sub-module, id_field_split, instantiated on the head entry.

Verification
REQ-037 Reset then single accept 0x8C2A0004 (lw), pc 0x3000, dst_sel 1, out_ready 1 -> next cycle out_valid 1, opcode 0x23, rs 1, rt 10, out_dst 10, imm 0x0004.
REQ-038 jal 0x0C000C00, pc 0x3004, dst_sel 2 -> out_dst 31, jidx 0x0000C00, out_link_pc 0x300C.
REQ-039 Stream 3 words, out_ready low -> in_ready low after 2 accepts, third held upstream; raise out_ready -> outputs in order 1,2,3, one per cycle.
REQ-040 Two entries held, flush with in_valid high -> next cycle out_valid 0, in_ready 1, drop_cnt +2, incoming word absent.
REQ-041 CNT_W=2, repeated flushes with 2 held -> drop_cnt 2, then 3, stays 3.
REQ-042 Continuous in_valid/out_ready high, 8 words -> 8 outputs on 8 consecutive cycles, in_ready never low.
